water_led_ctrl: RTL and testbench
=================================

Name: water_led_ctrl

Overview:
- Parametrised running-light controller driving LED_NUM board LEDs.
- A single one-hot light moves across the LEDs at a programmable rate.
- Selectable modes: rotate left, rotate right, bounce, hold.
- Also provides run/pause, a runtime speed divider and a step strobe for downstream logic such as a buzzer or a seven-segment step counter.
- Sits directly between the board clock/reset and the LED pins.

Parameters:
- LED_NUM, 4, number of LEDs. Legal range 2..32.
- CNT_WIDTH, 32, width of the base period counter.
- CNT_MAX, 32'd49_999_999, terminal count of the base counter. Base tick period is CNT_MAX+1 cycles, i.e. 0.5 s at 100 MHz. Benches override it to a small value.

Ports:
- clock, input, 1, board clock (100 MHz). All logic is on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- enable, input, 1, 1 = run, 0 = pause. While paused, all counters and outputs freeze.
- mode, input, 2, movement mode: 00 rotate left, 01 rotate right, 10 bounce, 11 hold.
- speed, input, 2, step divider. One step every 2^speed base ticks (1, 2, 4 or 8).
- led_out, output, LED_NUM, one-hot LED drive. Bit 0 is the rightmost LED.
- dir, output, 1, bounce direction: 0 = moving left (towards MSB), 1 = moving right.
- step_pulse, output, 1, high for one cycle, coincident with each new led_out value.

Behaviour:
- Reset (reset==0 at a clock edge):
  - base counter = 0, divider count = 0.
  - led_out = 1 (bit 0), dir = 0, step_pulse = 0.
  - Reset has priority over all other inputs, including mid-period.
- Base counter:
  - When enable=1, counts 0..CNT_MAX and then wraps to 0.
  - The base tick is the enabled cycle in which counter==CNT_MAX.
  - When enable=0, the counter holds its value; no tick and no step occur.
- Divider:
  - On each base tick, if div_cnt >= (2^speed)-1, a step fires and div_cnt returns to 0; otherwise div_cnt increments.
  - The >= comparison means a speed decrease mid-count steps at the next base tick and never stalls.
- Step timing:
  - led_out and dir update on the same edge that samples the tick.
  - step_pulse is registered: it is 1 in exactly the cycle where the new led_out first appears, and 0 otherwise.
  - The first step after reset release, with enable=1 and speed=0, is visible after CNT_MAX+1 edges.
- mode 00 (rotate left): led_out rotates left; MSB wraps to bit 0. dir is unchanged.
- mode 01 (rotate right): led_out rotates right; bit 0 wraps to MSB. dir is unchanged.
- mode 10 (bounce):
  - If dir==0 and led_out[MSB]==1: dir becomes 1 and led_out shifts right in the same step.
  - If dir==1 and led_out[0]==1: dir becomes 0 and led_out shifts left.
  - Otherwise led_out shifts in the direction given by dir.
  - End LEDs are never repeated. The period is 2*LED_NUM-2 steps.
- mode 11 (hold):
  - Counters keep running.
  - led_out, dir and step_pulse stay unchanged/0.
- Mode change: takes effect at the next step. Entering bounce uses the current dir.
- Integrity guard: if led_out is ever non-one-hot at a step, it loads 1 and dir is cleared.
- Timing: no combinational path from inputs to outputs; all outputs are registered.

Test Plan (LED_NUM=4, CNT_MAX=3, so the base period is 4 cycles):
1. Reset and rotate left:
   - Hold reset=0 for 3 cycles -> led_out=0001, dir=0, step_pulse=0.
   - Release with enable=1, mode=00, speed=0 -> step_pulse at edges 4, 8, 12, 16.
   - led_out sequence 0010, 0100, 1000, 0001.
2. Rotate right:
   - mode=01 from reset -> led_out 1000, 0100, 0010, 0001, 1000.
   - step_pulse every 4 cycles.
3. Bounce:
   - mode=10 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
   - dir rises with the first 0100 after 1000, and falls with the 0010 after 0001.
4. Speed:
   - speed=2 -> steps every 16 cycles.
   - speed=3 with div_cnt=5, then switched to speed=0 -> step at the next base tick, then every 4 cycles.
5. Pause and hold:
   - enable=0 for 10 cycles mid-period -> the next step arrives exactly 10 cycles later than nominal, with led_out frozen meanwhile.
   - mode=11 for 20 cycles -> no step_pulse, led_out constant.
6. Reset mid-operation:
   - reset=0 for 1 cycle while led_out=0100 with counter=2 -> next cycle led_out=0001, dir=0, step_pulse=0.
   - First step 4 edges after release.

Source files
------------

// File: rtl/water_led_ctrl.sv
// Running-light controller. One lit LED moves across LED_NUM board LEDs
// at a programmable rate. Modes: rotate left, rotate right, bounce, hold.
// It also provides run/pause, a runtime step divider and a one-cycle step
// strobe for downstream consumers.
//
// Handshake: there is none. All inputs are level-sampled on the rising
// clock edge. All outputs are registered. step_pulse is high only in the
// cycle where a new led_out value first appears.
module water_led_ctrl #(
  parameter int                   LED_NUM   = 4,
  parameter int                   CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] CNT_MAX   = 32'd49_999_999
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [LED_NUM-1:0] led_out,
  output logic               dir,
  output logic               step_pulse
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [LED_NUM-1:0]   LED_ONE = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  mode_e                mode_sel;
  logic [CNT_WIDTH-1:0] base_cnt;
  logic [2:0]           div_cnt;
  logic [3:0]           div_limit;
  logic                 base_tick;
  logic                 step_fire;
  logic                 move;
  logic                 led_onehot;
  logic [LED_NUM-1:0]   led_rol;
  logic [LED_NUM-1:0]   led_ror;
  logic [LED_NUM-1:0]   led_next;
  logic                 dir_next;

  assign mode_sel   = mode_e'(mode);
  assign base_tick  = enable && (base_cnt == CNT_MAX);
  // The terminal divider value is 2^speed - 1. The >= compare means a
  // speed decrease mid-count fires at the next tick instead of stalling.
  assign div_limit  = (4'd1 << speed) - 4'd1;
  assign step_fire  = base_tick && ({1'b0, div_cnt} >= div_limit);
  // In hold mode the counters keep running, but the LEDs never move.
  assign move       = step_fire && (mode_sel != MODE_HOLD);
  assign led_rol    = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
  assign led_ror    = {led_out[0], led_out[LED_NUM-1:1]};
  assign led_onehot = (led_out != '0) && ((led_out & (led_out - LED_ONE)) == '0);

  // Next LED pattern and bounce direction for a step in the current mode.
  always_comb begin
    led_next = led_out;
    dir_next = dir;
    if (!led_onehot) begin
      // If the pattern is corrupted, recover to a known state instead of
      // propagating the corruption.
      led_next = LED_ONE;
      dir_next = 1'b0;
    end else begin
      case (mode_sel)
        MODE_LEFT:  led_next = led_rol;
        MODE_RIGHT: led_next = led_ror;
        MODE_BOUNCE: begin
          // Turning at an end and moving happen in the same step, so the
          // end LEDs are never shown twice in a row.
          if (!dir && led_out[LED_NUM-1]) begin
            dir_next = 1'b1;
            led_next = led_ror;
          end else if (dir && led_out[0]) begin
            dir_next = 1'b0;
            led_next = led_rol;
          end else if (dir) begin
            led_next = led_ror;
          end else begin
            led_next = led_rol;
          end
        end
        default: begin
          led_next = led_out;
          dir_next = dir;
        end
      endcase
    end
  end

  // Base period counter, step divider, and registered LED/strobe outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      base_cnt   <= '0;
      div_cnt    <= '0;
      led_out    <= LED_ONE;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      // The strobe is tied to a real LED change. It never stretches,
      // even if enable drops right after a step.
      step_pulse <= move;
      if (enable) begin
        if (base_tick) begin
          base_cnt <= '0;
          div_cnt  <= step_fire ? 3'd0 : div_cnt + 3'd1;
        end else begin
          base_cnt <= base_cnt + CNT_ONE;
        end
        if (move) begin
          led_out <= led_next;
          dir     <= dir_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_water_led_ctrl.sv
// Bench for water_led_ctrl with LED_NUM=4 and CNT_MAX=3.
// The reference model tracks the lit LED as an integer position and the
// timing as plain integers. Expected outputs come from that model and from
// fixed sequence tables.
module tb_water_led_ctrl;

  localparam int N    = 4;
  localparam int CMAX = 3;

  logic         clock  = 1'b0;
  logic         reset  = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   mode   = 2'b00;
  logic [1:0]   speed  = 2'b00;
  logic [N-1:0] led_out;
  logic         dir;
  logic         step_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int   m_cnt   = 0;
  int   m_div   = 0;
  int   m_pos   = 0;
  logic m_dir   = 1'b0;
  logic m_pulse = 1'b0;

  water_led_ctrl #(
    .LED_NUM  (N),
    .CNT_WIDTH(32),
    .CNT_MAX  (32'd3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .speed     (speed),
    .led_out   (led_out),
    .dir       (dir),
    .step_pulse(step_pulse)
  );

  // Clock generation.
  always #5 clock = ~clock;

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] one;
    one = 1;
    return one << m_pos;
  endfunction

  // One rising edge of behaviour, computed from position arithmetic.
  task automatic model_edge();
    if (!reset) begin
      m_cnt = 0; m_div = 0; m_pos = 0; m_dir = 1'b0; m_pulse = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    if (!enable) return;
    if (m_cnt != CMAX) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    if (m_div < (1 << speed) - 1) begin
      m_div++;
      return;
    end
    m_div = 0;
    if (mode == 2'b11) return;
    m_pulse = 1'b1;
    case (mode)
      2'b00: m_pos = (m_pos + 1) % N;
      2'b01: m_pos = (m_pos + N - 1) % N;
      default: begin
        if (!m_dir && m_pos == N - 1) m_dir = 1'b1;
        else if (m_dir && m_pos == 0) m_dir = 1'b0;
        m_pos = m_dir ? m_pos - 1 : m_pos + 1;
      end
    endcase
  endtask

  // Advance one clock. Inputs are sampled at posedge; outputs are read at negedge.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; mode = 2'b00; speed = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (led_out !== 4'b0001 || dir !== 1'b0 || step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got led=%b dir=%b pulse=%b, want led=0001 dir=0 pulse=0",
                 i, led_out, dir, step_pulse);
      end
    end
  endtask

  task automatic test_rotate_left();
    logic [N-1:0] seq [4];
    int           edges [4];
    int           k;
    seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    edges = '{4, 8, 12, 16};
    k = 0;
    reset = 1'b1; enable = 1'b1; mode = 2'b00; speed = 2'b00;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      checks++;
      if (led_out !== exp_led() || dir !== m_dir || step_pulse !== m_pulse) begin
        errors++;
        $display("FAIL rotl edge%0d: got led=%b dir=%b pulse=%b, want led=%b dir=%b pulse=%b",
                 e, led_out, dir, step_pulse, exp_led(), m_dir, m_pulse);
      end
      if (step_pulse) begin
        if (k < 4) begin
          checks++;
          if (e != edges[k] || led_out !== seq[k]) begin
            errors++;
            $display("FAIL rotl_seq step%0d: got edge=%0d led=%b, want edge=%0d led=%b",
                     k, e, led_out, edges[k], seq[k]);
          end
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL rotl_count: got %0d steps, want 4", k);
    end
  endtask

  task automatic test_rotate_right();
    logic [N-1:0] seq [5];
    int           k;
    seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    k = 0;
    reset = 1'b0; mode = 2'b01; speed = 2'b00; enable = 1'b1;
    cycle();
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      checks++;
      if (led_out !== exp_led() || dir !== m_dir || step_pulse !== m_pulse) begin
        errors++;
        $display("FAIL rotr edge%0d: got led=%b dir=%b pulse=%b, want led=%b dir=%b pulse=%b",
                 e, led_out, dir, step_pulse, exp_led(), m_dir, m_pulse);
      end
      if (step_pulse) begin
        checks++;
        if (k >= 5 || e != 4 * (k + 1) || led_out !== seq[k]) begin
          errors++;
          $display("FAIL rotr_seq step%0d: got edge=%0d led=%b", k, e, led_out);
        end
        k++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq [8];
    logic         dseq [8];
    int           k;
    seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    dseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    k = 0;
    reset = 1'b0; mode = 2'b10; speed = 2'b00; enable = 1'b1;
    cycle();
    reset = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      cycle();
      checks++;
      if (led_out !== exp_led() || dir !== m_dir || step_pulse !== m_pulse) begin
        errors++;
        $display("FAIL bounce edge%0d: got led=%b dir=%b pulse=%b, want led=%b dir=%b pulse=%b",
                 e, led_out, dir, step_pulse, exp_led(), m_dir, m_pulse);
      end
      if (step_pulse) begin
        checks++;
        if (k >= 8 || led_out !== seq[k] || dir !== dseq[k]) begin
          errors++;
          $display("FAIL bounce_seq step%0d: got led=%b dir=%b", k, led_out, dir);
        end
        k++;
      end
    end
  endtask

  task automatic test_speed();
    int wait_n;
    // speed=2 gives one step every 16 cycles.
    reset = 1'b0; mode = 2'b00; speed = 2'd2; enable = 1'b1;
    cycle();
    reset = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      cycle();
      checks++;
      if (step_pulse !== ((e % 16) == 0) || led_out !== exp_led()) begin
        errors++;
        $display("FAIL speed2 edge%0d: got pulse=%b led=%b, want pulse=%b led=%b",
                 e, step_pulse, led_out, ((e % 16) == 0), exp_led());
      end
    end
    // speed=3, five ticks in, then drop to speed=0.
    reset = 1'b0; speed = 2'd3;
    cycle();
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      checks++;
      if (step_pulse !== 1'b0 || led_out !== exp_led()) begin
        errors++;
        $display("FAIL speed3 edge%0d: got pulse=%b led=%b, want pulse=0 led=%b",
                 e, step_pulse, led_out, exp_led());
      end
    end
    speed = 2'd0;
    for (int s = 0; s < 2; s++) begin
      wait_n = 0;
      do begin
        cycle();
        wait_n++;
      end while (!step_pulse && wait_n < 40);
      checks++;
      if (wait_n != 4 || led_out !== exp_led()) begin
        errors++;
        $display("FAIL speed_drop step%0d: got wait=%0d led=%b, want wait=4 led=%b",
                 s, wait_n, led_out, exp_led());
      end
    end
  endtask

  task automatic test_pause_hold();
    int           wait_n;
    logic [N-1:0] held;
    reset = 1'b0; mode = 2'b00; speed = 2'd0; enable = 1'b1;
    cycle();
    reset = 1'b1;
    for (int e = 0; e < 6; e++) cycle();
    enable = 1'b0;
    for (int e = 0; e < 10; e++) begin
      cycle();
      checks++;
      if (led_out !== 4'b0010 || step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL pause cyc%0d: got led=%b pulse=%b, want led=0010 pulse=0",
                 e, led_out, step_pulse);
      end
    end
    enable = 1'b1;
    wait_n = 0;
    do begin
      cycle();
      wait_n++;
    end while (!step_pulse && wait_n < 40);
    checks++;
    if (wait_n != 2 || led_out !== 4'b0100) begin
      errors++;
      $display("FAIL pause_resume: got wait=%0d led=%b, want wait=2 led=0100", wait_n, led_out);
    end
    mode = 2'b11;
    held = led_out;
    for (int e = 0; e < 20; e++) begin
      cycle();
      checks++;
      if (led_out !== held || step_pulse !== 1'b0 || dir !== m_dir) begin
        errors++;
        $display("FAIL hold cyc%0d: got led=%b pulse=%b, want led=%b pulse=0",
                 e, led_out, step_pulse, held);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wait_n;
    reset = 1'b0; mode = 2'b00; speed = 2'd0; enable = 1'b1;
    cycle();
    reset = 1'b1;
    for (int e = 0; e < 10; e++) cycle();
    checks++;
    if (led_out !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_pre: got led=%b, want led=0100", led_out);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (led_out !== 4'b0001 || dir !== 1'b0 || step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rstmid: got led=%b dir=%b pulse=%b, want led=0001 dir=0 pulse=0",
               led_out, dir, step_pulse);
    end
    reset = 1'b1;
    wait_n = 0;
    do begin
      cycle();
      wait_n++;
    end while (!step_pulse && wait_n < 40);
    checks++;
    if (wait_n != 4 || led_out !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_first: got wait=%0d led=%b, want wait=4 led=0010", wait_n, led_out);
    end
  endtask

  task automatic test_random();
    reset = 1'b0;
    cycle();
    for (int e = 0; e < 3000; e++) begin
      reset  = ($urandom_range(0, 63) != 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
      cycle();
      checks++;
      if (led_out !== exp_led() || dir !== m_dir || step_pulse !== m_pulse) begin
        errors++;
        $display("FAIL random cyc%0d: got led=%b dir=%b pulse=%b, want led=%b dir=%b pulse=%b",
                 e, led_out, dir, step_pulse, exp_led(), m_dir, m_pulse);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    @(negedge clock);
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_speed();
    test_pause_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
